// File: rtl/otter_dcache_nway.sv
// otter_dcache_nway: N-way set-associative write-back data cache, true-LRU, flop arrays.
// Optional feature: define CACHE_STATS_EN to add the stat_hits/stat_misses counters.
module otter_dcache_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              MEM_CLK,
  input  logic              MEM_RST,
  input  logic              MEM_RDEN2,
  input  logic              MEM_WE2,
  input  logic [ADDR_W-1:0] MEM_ADDR2,
  input  logic [31:0]       MEM_DIN2,
  input  logic [1:0]        MEM_SIZE,
  input  logic              MEM_SIGN,
  output logic [31:0]       MEM_DOUT2,
  output logic              MEM_VALID2,
  output logic              ERR,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int BW     = $clog2(LINE_WORDS);
  localparam int OFF    = BW + 2;
  localparam int IDX    = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF - IDX;
  localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WAY_W  = AGE_W;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [31:0]      data_q  [WAYS][SETS][LINE_WORDS];
  logic [SETS-1:0]  valid_q [WAYS];
  logic [SETS-1:0]  dirty_q [WAYS];
  logic [AGE_W-1:0] age_q   [WAYS][SETS];

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [TAG_W-1:0] ptag_q, ptag_d;
  logic [IDX-1:0]   pidx_q, pidx_d;

  logic [IDX-1:0]   req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [BW-1:0]    req_word;
  logic [1:0]       req_lane;

  assign req_idx  = MEM_ADDR2[OFF+IDX-1:OFF];
  assign req_tag  = MEM_ADDR2[ADDR_W-1:OFF+IDX];
  assign req_word = MEM_ADDR2[OFF-1:2];
  assign req_lane = MEM_ADDR2[1:0];

  logic req, bad, in_idle, acc_ok, hit_ok, miss;
  logic [WAYS-1:0]  hit_vec;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic [AGE_W-1:0] hit_age;
  logic [WAY_W-1:0] vic;
  logic             vic_found;
  logic             vic_dirty;
  logic             beat_last;
  logic             fill_done;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_hit
      assign hit_vec[gi] = valid_q[gi][req_idx] && (tag_q[gi][req_idx] == req_tag);
    end
  endgenerate

  assign hit_any = |hit_vec;

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit_age = age_q[hit_way][req_idx];

  // Lowest-index invalid way wins; otherwise the oldest way (age WAYS-1).
  always_comb begin
    vic       = '0;
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_q[w][req_idx] && !vic_found) begin
        vic       = WAY_W'(w);
        vic_found = 1'b1;
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w][req_idx] == AGE_W'(WAYS - 1)) vic = WAY_W'(w);
      end
    end
    if (WAYS == 1) vic = '0;
  end

  assign vic_dirty = valid_q[vic][req_idx] && dirty_q[vic][req_idx];

  assign req     = MEM_RDEN2 | MEM_WE2;
  assign bad     = (MEM_SIZE == 2'd3)
                 | ((MEM_SIZE == 2'd1) && req_lane[0])
                 | ((MEM_SIZE == 2'd2) && (req_lane != 2'b00))
                 | (MEM_RDEN2 && MEM_WE2);
  assign in_idle = (state_q == S_IDLE) && !MEM_RST;
  assign acc_ok  = in_idle && req && !bad;
  assign hit_ok  = acc_ok && hit_any;
  assign miss    = acc_ok && !hit_any;

  assign ERR        = in_idle && req && bad;
  assign MEM_VALID2 = hit_ok;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdat;
  logic [31:0] hit_word;
  logic [31:0] lane_sh;
  logic [31:0] load_data;

  always_comb begin
    lane_be   = 4'b1111;
    lane_wdat = MEM_DIN2;
    case (MEM_SIZE)
      2'd0: begin
        lane_be   = 4'b0001 << req_lane;
        lane_wdat = {4{MEM_DIN2[7:0]}};
      end
      2'd1: begin
        lane_be   = req_lane[1] ? 4'b1100 : 4'b0011;
        lane_wdat = {2{MEM_DIN2[15:0]}};
      end
      default: begin
        lane_be   = 4'b1111;
        lane_wdat = MEM_DIN2;
      end
    endcase
  end

  // MEM_SIGN=1 selects zero-extension, 0 sign-extension.
  always_comb begin
    hit_word = data_q[hit_way][req_idx][req_word];
    lane_sh  = hit_word >> {req_lane, 3'b000};
    case (MEM_SIZE)
      2'd0:    load_data = MEM_SIGN ? {24'h0, lane_sh[7:0]}  : {{24{lane_sh[7]}}, lane_sh[7:0]};
      2'd1:    load_data = MEM_SIGN ? {16'h0, lane_sh[15:0]} : {{16{lane_sh[15]}}, lane_sh[15:0]};
      default: load_data = hit_word;
    endcase
  end

  assign MEM_DOUT2 = (hit_ok && MEM_RDEN2) ? load_data : 32'h0;

  assign beat_last = (beat_q == BW'(LINE_WORDS - 1));
  assign fill_done = (state_q == S_FILL) && mem_ack && beat_last;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    victim_d  = victim_q;
    ptag_d    = ptag_q;
    pidx_d    = pidx_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          victim_d = vic;
          ptag_d   = req_tag;
          pidx_d   = req_idx;
          beat_d   = '0;
          state_d  = vic_dirty ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[victim_q][pidx_q], pidx_q, beat_q, 2'b00};
        mem_wdata = data_q[victim_q][pidx_q][beat_q];
        if (mem_ack) begin
          beat_d = beat_last ? '0 : beat_q + 1'b1;
          if (beat_last) state_d = S_FILL;
        end
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {ptag_q, pidx_q, beat_q, 2'b00};
        if (mem_ack) begin
          beat_d = beat_last ? '0 : beat_q + 1'b1;
          if (beat_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      victim_q <= '0;
      ptag_q   <= '0;
      pidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
      ptag_q   <= ptag_d;
      pidx_q   <= pidx_d;
    end
  end

  // Tag and data storage is never cleared; valid bits alone qualify it.
  always_ff @(posedge MEM_CLK) begin
    for (int w = 0; w < WAYS; w++) begin
      if (hit_ok && MEM_WE2 && (WAY_W'(w) == hit_way)) begin
        for (int l = 0; l < 4; l++) begin
          if (lane_be[l]) data_q[w][req_idx][req_word][8*l +: 8] <= lane_wdat[8*l +: 8];
        end
      end
      if ((state_q == S_FILL) && mem_ack && (WAY_W'(w) == victim_q)) begin
        data_q[w][pidx_q][beat_q] <= mem_rdata;
        if (beat_last) tag_q[w][pidx_q] <= ptag_q;
      end
    end
  end

  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
        for (int s = 0; s < SETS; s++) age_q[w][s] <= AGE_W'(w);
      end
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (hit_ok) begin
          if (WAY_W'(w) == hit_way) begin
            age_q[w][req_idx] <= '0;
            if (MEM_WE2) dirty_q[w][req_idx] <= 1'b1;
          end else if (age_q[w][req_idx] < hit_age) begin
            age_q[w][req_idx] <= age_q[w][req_idx] + 1'b1;
          end
        end
        if ((state_q == S_WB) && mem_ack && beat_last && (WAY_W'(w) == victim_q))
          dirty_q[w][pidx_q] <= 1'b0;
        if (fill_done && (WAY_W'(w) == victim_q)) begin
          valid_q[w][pidx_q] <= 1'b1;
          dirty_q[w][pidx_q] <= 1'b0;
        end
      end
    end
  end

`ifdef CACHE_STATS_EN
  // The hit that replays a just-filled request was already counted as a miss.
  logic replay_q;

  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) begin
      stat_hits   <= 32'h0;
      stat_misses <= 32'h0;
      replay_q    <= 1'b0;
    end else begin
      replay_q <= fill_done;
      if (hit_ok && !replay_q) stat_hits <= stat_hits + 32'd1;
      if (miss) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_otter_dcache_nway.sv
// Bench for otter_dcache_nway: vector table, eviction and reset sequences, random pairs.
module tb_otter_dcache_nway;

  logic        clk;
  logic        MEM_RST, MEM_RDEN2, MEM_WE2, MEM_SIGN;
  logic [31:0] MEM_ADDR2, MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic [31:0] MEM_DOUT2;
  logic        MEM_VALID2, ERR;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  otter_dcache_nway dut (
    .MEM_CLK    (clk),
    .MEM_RST    (MEM_RST),
    .MEM_RDEN2  (MEM_RDEN2),
    .MEM_WE2    (MEM_WE2),
    .MEM_ADDR2  (MEM_ADDR2),
    .MEM_DIN2   (MEM_DIN2),
    .MEM_SIZE   (MEM_SIZE),
    .MEM_SIGN   (MEM_SIGN),
    .MEM_DOUT2  (MEM_DOUT2),
    .MEM_VALID2 (MEM_VALID2),
    .ERR        (ERR),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int fails  = 0;
  bit stall_en = 1'b0;
  logic last_mreq;

  logic [31:0] bmem    [int];
  logic [31:0] ref_mem [int];
  logic [31:0] wb_log  [$];
  logic [31:0] exp_q   [$];

  function automatic logic [31:0] init_val(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction

  function automatic logic [31:0] bm_rd(int i);
    return bmem.exists(i) ? bmem[i] : init_val(i);
  endfunction

  function automatic logic [31:0] ref_rd(int i);
    return ref_mem.exists(i) ? ref_mem[i] : bm_rd(i);
  endfunction

  // Backing memory: ack decided at the falling edge, held over the rising edge.
  always @(negedge clk) begin
    mem_ack   = mem_req && (!stall_en || ($urandom_range(0, 3) != 0));
    mem_rdata = bm_rd(int'(mem_addr[15:2]));
    if (mem_ack && mem_we) begin
      bmem[int'(mem_addr[15:2])] = mem_wdata;
      wb_log.push_back(mem_addr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_load(logic [31:0] a, logic [1:0] sz, bit sg);
    logic [31:0] w, sh;
    w  = ref_rd(int'(a[15:2]));
    sh = w >> (8 * a[1:0]);
    case (sz)
      2'd0:    return sg ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    return sg ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] w;
    int b;
    w = ref_rd(int'(a[15:2]));
    b = int'(a[1:0]);
    case (sz)
      2'd0:    w[8*b +: 8]  = d[7:0];
      2'd1:    w[8*b +: 16] = d[15:0];
      default: w = d;
    endcase
    ref_mem[int'(a[15:2])] = w;
  endtask

  task automatic do_reset();
    MEM_RST   = 1'b1;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    @(posedge clk); #1;
    MEM_RST = 1'b0;
    ref_mem.delete();
  endtask

  task automatic xact(input bit rd, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input bit sg,
                      output int lat, output logic err, output logic [31:0] dout);
    bit done;
    MEM_RDEN2 = rd; MEM_WE2 = we; MEM_ADDR2 = a; MEM_DIN2 = d; MEM_SIZE = sz; MEM_SIGN = sg;
    lat = 0; err = 1'b0; dout = 32'h0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (ERR || MEM_VALID2) begin
        done = 1'b1; err = ERR; dout = MEM_DOUT2; last_mreq = mem_req;
      end
      @(posedge clk); #1;
      if (!done) begin
        lat++;
        if (lat > 200) begin
          checks++; fails++;
          $display("FAIL timeout addr=%h: no MEM_VALID2/ERR after %0d cycles, required completion", a, lat);
          done = 1'b1;
        end
      end
    end
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
  endtask

  task automatic run(input string nm, input bit rd, input bit we, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] sz, input bit sg, input bit exp_err,
                     input int exp_lat, input int chk_mode, input logic [31:0] exp_d, output int lat_o);
    int lat;
    logic err;
    logic [31:0] dout, expv;
    bit pushed;
    pushed = 1'b0;
    if (rd && !we && !exp_err && chk_mode != 0) begin
      exp_q.push_back(chk_mode == 1 ? exp_d : mdl_load(a, sz, sg));
      pushed = 1'b1;
    end
    xact(rd, we, a, d, sz, sg, lat, err, dout);
    $display("%s rd=%0b we=%0b addr=%h size=%0d din=%h -> err=%0b lat=%0d dout=%h",
             nm, rd, we, a, sz, d, err, lat, dout);
    chk({nm, " err"}, 32'(err), 32'(exp_err));
    if (exp_err) chk({nm, " mem_req"}, 32'(last_mreq), 32'h0);
    if (exp_lat >= 0) chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    if (pushed) begin
      expv = exp_q.pop_front();
      chk({nm, " data"}, dout, expv);
    end
    if (we && !rd && !exp_err) mdl_store(a, d, sz);
    lat_o = lat;
  endtask

  typedef struct {
    bit          rst;
    bit          rd;
    bit          we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    bit          sign;
    bit          exp_err;
    int          exp_lat;
    int          chk_mode;
    logic [31:0] exp_d;
  } vec_t;

  function automatic vec_t mk(bit rst, bit rd, bit we, logic [31:0] a, logic [31:0] d,
                              logic [1:0] sz, bit sg, bit e, int lat, int cm, logic [31:0] x);
    vec_t v;
    v.rst = rst; v.rd = rd; v.we = we; v.addr = a; v.din = d; v.size = sz; v.sign = sg;
    v.exp_err = e; v.exp_lat = lat; v.chk_mode = cm; v.exp_d = x;
    return v;
  endfunction

  vec_t tbl [20];

  initial begin
    int lat, wb_base, nh, nm;
    bit found;
    logic [31:0] a, d;
    logic [1:0]  sz;
    bit sg;

    MEM_RDEN2 = 1'b0; MEM_WE2 = 1'b0; MEM_ADDR2 = 32'h0; MEM_DIN2 = 32'h0;
    MEM_SIZE = 2'd2; MEM_SIGN = 1'b0; MEM_RST = 1'b1; last_mreq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    MEM_RST = 1'b0;
    @(negedge clk);
    chk("reset MEM_VALID2", 32'(MEM_VALID2), 32'h0);
    chk("reset ERR", 32'(ERR), 32'h0);
    chk("reset mem_req", 32'(mem_req), 32'h0);
    chk("reset mem_we", 32'(mem_we), 32'h0);
    chk("reset MEM_DOUT2", MEM_DOUT2, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
`ifdef CACHE_STATS_EN
    chk("reset stat_hits", stat_hits, 32'h0);
    chk("reset stat_misses", stat_misses, 32'h0);
`endif
    @(posedge clk); #1;

    //               rst   rd    we    addr        din           sz    sgn   err   lat cm exp
    tbl[0]  = mk(1'b0, 1'b0, 1'b1, 32'h100,  32'hDEADBEEF, 2'd2, 1'b0, 1'b0,  9, 0, 32'h0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 32'h100,  32'h0,        2'd2, 1'b0, 1'b0,  0, 1, 32'hDEADBEEF);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 32'h100,  32'h0,        2'd2, 1'b0, 1'b0,  0, 1, 32'hDEADBEEF);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 32'h203,  32'h80,       2'd0, 1'b0, 1'b0,  9, 0, 32'h0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 32'h203,  32'h0,        2'd0, 1'b0, 1'b0,  0, 1, 32'hFFFFFF80);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 32'h203,  32'h0,        2'd0, 1'b1, 1'b0,  0, 1, 32'h00000080);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 32'h200,  32'h0,        2'd2, 1'b0, 1'b0,  0, 2, 32'h0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 32'h202,  32'h0,        2'd1, 1'b1, 1'b0,  0, 2, 32'h0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 32'h101,  32'h0,        2'd1, 1'b0, 1'b1,  0, 0, 32'h0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 32'h100,  32'h0,        2'd3, 1'b0, 1'b1,  0, 0, 32'h0);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 32'h102,  32'h0,        2'd2, 1'b0, 1'b1,  0, 0, 32'h0);
    tbl[11] = mk(1'b0, 1'b1, 1'b1, 32'h100,  32'h5555AAAA, 2'd2, 1'b0, 1'b1,  0, 0, 32'h0);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 32'h102,  32'h1234,     2'd1, 1'b0, 1'b0,  0, 0, 32'h0);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 32'h100,  32'h0,        2'd2, 1'b0, 1'b0,  0, 1, 32'h1234BEEF);
    tbl[14] = mk(1'b1, 1'b0, 1'b1, 32'h0000, 32'h11111111, 2'd2, 1'b0, 1'b0,  9, 0, 32'h0);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 32'h1000, 32'h22222222, 2'd2, 1'b0, 1'b0,  9, 0, 32'h0);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 32'h2000, 32'h33333333, 2'd2, 1'b0, 1'b0, 17, 0, 32'h0);
    tbl[17] = mk(1'b0, 1'b1, 1'b0, 32'h0000, 32'h0,        2'd2, 1'b0, 1'b0, 17, 1, 32'h11111111);
    tbl[18] = mk(1'b0, 1'b1, 1'b0, 32'h2000, 32'h0,        2'd2, 1'b0, 1'b0,  0, 1, 32'h33333333);
    tbl[19] = mk(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0,        2'd2, 1'b0, 1'b0,  9, 1, 32'h22222222);

    wb_base = wb_log.size();
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rst) do_reset();
      run($sformatf("vec%0d", i), tbl[i].rd, tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].size,
          tbl[i].sign, tbl[i].exp_err, tbl[i].exp_lat, tbl[i].chk_mode, tbl[i].exp_d, lat);
    end

    chk("writeback beat count", 32'(wb_log.size() - wb_base), 32'd16);
    if (wb_log.size() >= wb_base + 16) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("wb A beat%0d addr", k), wb_log[wb_base + k], 32'(4 * k));
        chk($sformatf("wb B beat%0d addr", k), wb_log[wb_base + 8 + k], 32'h1000 + 32'(4 * k));
      end
    end
    chk("backing word @0x0000", bm_rd(0), 32'h11111111);

    // Reset while beat 3 of a fill is on the bus.
    MEM_RDEN2 = 1'b1; MEM_WE2 = 1'b0; MEM_ADDR2 = 32'h420; MEM_SIZE = 2'd2; MEM_SIGN = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 32'h42C) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("rstfill beat3 reached", 32'(found), 32'h1);
    MEM_RST = 1'b1;
    MEM_RDEN2 = 1'b0;
    @(posedge clk); #1;
    chk("rstfill mem_req", 32'(mem_req), 32'h0);
    chk("rstfill mem_we", 32'(mem_we), 32'h0);
    chk("rstfill mem_addr", mem_addr, 32'h0);
    MEM_RST = 1'b0;
    ref_mem.delete();
    $display("reset applied during fill beat 3");
    run("rstfill reload", 1'b1, 1'b0, 32'h420, 32'h0, 2'd2, 1'b0, 1'b0, 9, 2, 32'h0, lat);
    run("rstfill lost C", 1'b1, 1'b0, 32'h2000, 32'h0, 2'd2, 1'b0, 1'b0, 9, 2, 32'h0, lat);

    // Random aligned store/load pairs with backing-memory stalls.
    do_reset();
    stall_en = 1'b1;
    nh = 0;
    nm = 0;
    for (int p = 0; p < 100; p++) begin
      sz = 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 65535));
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2) a[1:0] = 2'b00;
      d  = $urandom;
      sg = 1'($urandom_range(0, 1));
      run($sformatf("rnd%0d st", p), 1'b0, 1'b1, a, d, sz, 1'b0, 1'b0, -1, 0, 32'h0, lat);
      if (lat == 0) nh++; else nm++;
      run($sformatf("rnd%0d ld", p), 1'b1, 1'b0, a, 32'h0, sz, sg, 1'b0, -1, 2, 32'h0, lat);
      if (lat == 0) nh++; else nm++;
    end
    stall_en = 1'b0;
`ifdef CACHE_STATS_EN
    chk("stat_hits", stat_hits, 32'(nh));
    chk("stat_misses", stat_misses, 32'(nm));
    chk("stat total", stat_hits + stat_misses, 32'd200);
`endif
    $display("random phase: %0d hits, %0d misses", nh, nm);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
